uart_tx: RTL and testbench

8-bit UART transmitter, the transmit-side counterpart of the team's UART receiver. Accepts a byte through a ready/start handshake and serialises it onto tx_out as start bit, 8 data bits, optional parity bit and 1 or 2 stop bits. Each bit period is paced by an external baud strobe tx_tick from the shared baud generator.

---
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_tx.sv | 131 +++++++++++++
 tb/tb_uart_tx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake, baud strobe and serial line of the UART transmitter.
interface uart_tx_if;
  logic       tx_en;
  logic       tx_tick;
  logic       tx_start;
  logic [7:0] TX_DATA;
  logic       tx_out;
  logic       tx_ready;
  logic       tx_bussy;
  logic       tx_done;

  modport master (
    output tx_en, tx_tick, tx_start, TX_DATA,
    input  tx_out, tx_ready, tx_bussy, tx_done
  );

  modport slave (
    input  tx_en, tx_tick, tx_start, TX_DATA,
    output tx_out, tx_ready, tx_bussy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, data, optional parity, 1-2 stop bits,
// each bit held for one baud strobe interval.
module uart_tx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1,
  parameter bit LSB_FIRST  = 1'b1
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SYNC, START, DATA, PARITY, STOP
  } state_e;

  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;

  logic       accept;
  logic       head;
  logic [7:0] shifted;

  assign accept  = (state_q == IDLE) && bus.tx_en && bus.tx_start;
  assign head    = LSB_FIRST ? shift_q[0] : shift_q[7];
  assign shifted = LSB_FIRST ? {1'b0, shift_q[7:1]}
                             : {shift_q[6:0], 1'b0};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d = bus.TX_DATA;
          par_d   = (^bus.TX_DATA) ^ PARITY_ODD;
          state_d = SYNC;
        end
      end
      // Wait for a fresh strobe so the start bit lasts a full period.
      SYNC: begin
        if (bus.tx_tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bus.tx_tick) begin
          state_d = DATA;
          tx_d    = head;
          shift_d = shifted;
          cnt_d   = 3'd0;
        end
      end
      DATA: begin
        if (bus.tx_tick) begin
          if (cnt_q != 3'd7) begin
            cnt_d   = cnt_q + 3'd1;
            tx_d    = head;
            shift_d = shifted;
          end else if (PARITY_EN) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            cnt_d   = 3'd0;
          end
        end
      end
      PARITY: begin
        if (bus.tx_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = 3'd0;
        end
      end
      STOP: begin
        if (bus.tx_tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= 8'd0;
      cnt_q   <= 3'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_out   = tx_q;
  assign bus.tx_ready = (state_q == IDLE) && bus.tx_en;
  assign bus.tx_bussy = (state_q != IDLE);
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: three configurations, frames decoded
// from the serial line and compared against hand-written bit strings.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       tick;
  logic       st  [3];
  logic [7:0] dat [3];

  logic out_s  [3];
  logic rdy_s  [3];
  logic bsy_s  [3];
  logic done_s [3];

  int total = 0;
  int bad   = 0;

  logic [11:0] q0 [$];
  logic [11:0] q1 [$];
  logic [11:0] q2 [$];

  always #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  assign if0.tx_en = en;
  assign if1.tx_en = en;
  assign if2.tx_en = en;
  assign if0.tx_tick = tick;
  assign if1.tx_tick = tick;
  assign if2.tx_tick = tick;
  assign if0.tx_start = st[0];
  assign if1.tx_start = st[1];
  assign if2.tx_start = st[2];
  assign if0.TX_DATA = dat[0];
  assign if1.TX_DATA = dat[1];
  assign if2.TX_DATA = dat[2];

  assign out_s[0]  = if0.tx_out;
  assign out_s[1]  = if1.tx_out;
  assign out_s[2]  = if2.tx_out;
  assign rdy_s[0]  = if0.tx_ready;
  assign rdy_s[1]  = if1.tx_ready;
  assign rdy_s[2]  = if2.tx_ready;
  assign bsy_s[0]  = if0.tx_bussy;
  assign bsy_s[1]  = if1.tx_bussy;
  assign bsy_s[2]  = if2.tx_bussy;
  assign done_s[0] = if0.tx_done;
  assign done_s[1] = if1.tx_done;
  assign done_s[2] = if2.tx_done;

  // 8N1, LSB first
  uart_tx u0 (.clk(clk), .rst(rst), .bus(if0.slave));

  // even parity, 2 stop bits
  uart_tx #(
    .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2), .LSB_FIRST(1'b1)
  ) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // odd parity, 1 stop bit, MSB first
  uart_tx #(
    .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1), .LSB_FIRST(1'b0)
  ) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

  initial begin : tickgen
    int tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tc == 15);
      tc   = (tc + 1) % 16;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_q(input int d, input logic [11:0] e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qn(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [11:0] pop_q(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Line monitor: finds a start bit, samples mid-bit, checks tx_done
  // lands exactly at the end of the last stop bit.
  task automatic mon(input int d);
    int          n;
    logic [11:0] v;
    logic [11:0] e;
    bit          ab;
    bit          early;
    bit          bsy_ok;
    logic        dn;
    case (d)
      0:       n = 10;
      1:       n = 12;
      default: n = 11;
    endcase
    @(negedge clk);
    forever begin
      while (!(rst === 1'b1 && out_s[d] === 1'b0)) @(negedge clk);
      v      = '0;
      ab     = 1'b0;
      early  = 1'b0;
      bsy_ok = 1'b1;
      dn     = 1'b0;
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < ((i == 0) ? 8 : 16); k++) begin
          @(negedge clk);
          if (!rst) begin
            ab = 1'b1;
            break;
          end
          early |= done_s[d];
        end
        if (ab) break;
        v = {v[10:0], out_s[d]};
        bsy_ok &= bsy_s[d];
      end
      if (!ab) begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (!rst) begin
            ab = 1'b1;
            break;
          end
          if (k < 7) early |= done_s[d];
          else dn = done_s[d];
        end
      end
      if (!ab) begin
        if (qn(d) == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame dut%0d: got %0h want none", d, v);
        end else begin
          e = pop_q(d);
          chk($sformatf("frame_dut%0d", d), v, e);
          chk($sformatf("done_pulse_dut%0d", d), {early, dn}, 2'b01);
          chk($sformatf("busy_frame_dut%0d", d), bsy_ok, 1'b1);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic send(input int d, input logic [7:0] b,
                      input logic [11:0] e, input bit push);
    int t;
    t = 0;
    while (!rdy_s[d] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!rdy_s[d]) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d: ready=%0b want 1", d, rdy_s[d]);
      return;
    end
    st[d]  = 1'b1;
    dat[d] = b;
    if (push) push_q(d, e);
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((bsy_s[0] || bsy_s[1] || bsy_s[2]) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_in_time", (t < 5000), 1'b1);
  endtask

  initial begin : main
    int k;
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    chk("rst_out", out_s[0], 1'b1);
    chk("rst_busy", bsy_s[0], 1'b0);
    chk("rst_done", done_s[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_en0", rdy_s[0], 1'b0);
    en = 1'b1;
    #1;
    chk("ready_en1", rdy_s[0], 1'b1);
    @(negedge clk);

    send(0, 8'hA5, 12'b0101001011, 1'b1);
    send(1, 8'hA5, 12'b010100101011, 1'b1);
    send(2, 8'h00, 12'b00000000011, 1'b1);
    send(2, 8'h01, 12'b00000000101, 1'b1);

    wait_idle();
    en     = 1'b0;
    st[0]  = 1'b1;
    dat[0] = 8'h3C;
    @(negedge clk);
    st[0] = 1'b0;
    chk("en0_ignored", bsy_s[0], 1'b0);
    en = 1'b1;
    send(0, 8'h55, 12'b0101010101, 1'b1);
    repeat (40) @(negedge clk);
    chk("busy_not_ready", rdy_s[0], 1'b0);
    st[0]  = 1'b1;
    dat[0] = 8'h3C;
    @(negedge clk);
    st[0]  = 1'b0;
    dat[0] = 8'hFF;
    repeat (20) @(negedge clk);
    en = 1'b0;
    chk("en_drop_busy", bsy_s[0], 1'b1);
    wait_idle();
    en = 1'b1;
    @(negedge clk);

    send(0, 8'h55, 12'b0101010101, 1'b1);
    k = 0;
    while (!rdy_s[0] && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_done_with_ready", done_s[0], 1'b1);
    send(0, 8'h0F, 12'b0111100001, 1'b1);
    k = 0;
    while (out_s[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_gap", k, 15);

    wait_idle();
    send(0, 8'hF0, 12'd0, 1'b0);
    k = 0;
    while (out_s[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (72) @(negedge clk);
    chk("pre_rst_bit3", out_s[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_mid_out", out_s[0], 1'b1);
    chk("rst_mid_busy", bsy_s[0], 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_mid_done", done_s[0], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    send(0, 8'hFF, 12'b0111111111, 1'b1);

    k = 0;
    while ((qn(0) + qn(1) + qn(2)) != 0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    chk("left_q0", qn(0), 0);
    chk("left_q1", qn(1), 0);
    chk("left_q2", qn(2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
